brg_cgra_mem_adapter: RTL

BRG_CGRA_MEM_ADAPTER -- requirements
Module: brg_cgra_mem_adapter

---
 rtl/brg_cgra_mem_adapter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/brg_cgra_mem_adapter.sv
// Bridges a CGRA load/store port to a manycore endpoint and returns responses in request order.
// Define BRG_CGRA_MEM_ADAPTER_STATS_EN to add the stat_req_o / stat_stall_o counters.
module brg_cgra_mem_adapter #(
  parameter x_cord_width_p = "inv",
  parameter y_cord_width_p = "inv",
  parameter int data_width_p = 32,
  parameter int addr_width_p = 32,
  parameter int max_out_credits_p = 200,
  parameter int rob_els_p = 4,
  localparam int packet_width_lp = addr_width_p + 2 + 4 + 5 + data_width_p
                                   + 2*x_cord_width_p + 2*y_cord_width_p,
  localparam int credit_width_lp = $clog2(max_out_credits_p+1)
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [x_cord_width_p-1:0]  my_x_i,
  input  logic [y_cord_width_p-1:0]  my_y_i,
  input  logic [x_cord_width_p-1:0]  dest_x_i,
  input  logic [y_cord_width_p-1:0]  dest_y_i,
  input  logic                       cgra_req_v_i,
  input  logic                       cgra_req_we_i,
  input  logic [31:0]                cgra_req_addr_i,
  input  logic [data_width_p-1:0]    cgra_req_data_i,
  output logic                       cgra_req_ready_o,
  output logic                       cgra_resp_v_o,
  output logic [data_width_p-1:0]    cgra_resp_data_o,
  input  logic                       cgra_resp_yumi_i,
  output logic                       out_v_o,
  output logic [packet_width_lp-1:0] out_packet_o,
  input  logic                       out_ready_i,
  input  logic [credit_width_lp-1:0] out_credits_i,
  input  logic                       returned_v_r_i,
  input  logic [data_width_p-1:0]    returned_data_r_i,
  input  logic [4:0]                 returned_reg_id_r_i,
  output logic                       returned_yumi_o,
  output logic                       idle_o
`ifdef BRG_CGRA_MEM_ADAPTER_STATS_EN
  ,
  output logic [31:0]                stat_req_o,
  output logic [31:0]                stat_stall_o
`endif
);

  localparam int lg_els_lp    = (rob_els_p > 1) ? $clog2(rob_els_p) : 1;
  localparam int cnt_width_lp = $clog2(rob_els_p+1);
  localparam logic [cnt_width_lp-1:0] full_count_lp = cnt_width_lp'(rob_els_p);
  localparam logic [lg_els_lp-1:0]    last_idx_lp   = lg_els_lp'(rob_els_p-1);

  typedef enum logic [1:0] {
    e_remote_load  = 2'b00,
    e_remote_store = 2'b01
  } op_e;

  // Field order, MSB first, must match the endpoint's bsg_manycore_packet_s.
  typedef struct packed {
    logic [addr_width_p-1:0]   addr;
    op_e                       op;
    logic [3:0]                mask;
    logic [4:0]                reg_id;
    logic [data_width_p-1:0]   data;
    logic [y_cord_width_p-1:0] src_y_cord;
    logic [x_cord_width_p-1:0] src_x_cord;
    logic [y_cord_width_p-1:0] y_cord;
    logic [x_cord_width_p-1:0] x_cord;
  } packet_s;

  logic [lg_els_lp-1:0]    head, tail, ret_idx;
  logic [cnt_width_lp-1:0] count;
  logic [rob_els_p-1:0]    valid;
  logic [data_width_p-1:0] data_mem [rob_els_p];
  logic                    space, alloc, deq;
  packet_s                 pkt;
  logic                    unused_tag_bits;

  function automatic logic [lg_els_lp-1:0] next_idx(input logic [lg_els_lp-1:0] idx);
    return (idx == last_idx_lp) ? '0 : idx + 1'b1;
  endfunction

  assign space            = (count < full_count_lp);
  assign cgra_req_ready_o = out_ready_i & (out_credits_i != '0) & space;
  assign alloc            = cgra_req_v_i & cgra_req_ready_o;
  assign out_v_o          = alloc;

  assign ret_idx          = returned_reg_id_r_i[lg_els_lp-1:0];
  assign unused_tag_bits  = ^returned_reg_id_r_i;
  assign returned_yumi_o  = returned_v_r_i;

  assign cgra_resp_v_o    = valid[head];
  assign cgra_resp_data_o = data_mem[head];
  assign deq              = cgra_resp_v_o & cgra_resp_yumi_i;
  assign idle_o           = (count == '0);

  always_comb begin
    pkt            = '0;
    pkt.addr       = addr_width_p'({2'b00, cgra_req_addr_i[31:2]});
    pkt.op         = cgra_req_we_i ? e_remote_store : e_remote_load;
    pkt.mask       = 4'hF;
    pkt.reg_id     = 5'(tail);
    pkt.data       = cgra_req_data_i;
    pkt.src_y_cord = my_y_i;
    pkt.src_x_cord = my_x_i;
    pkt.y_cord     = dest_y_i;
    pkt.x_cord     = dest_x_i;
  end

  assign out_packet_o = pkt;

  // NOTE: sequential state uses non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
    end else begin
      if (alloc) begin
        valid[tail] <= 1'b0;
        tail        <= next_idx(tail);
      end
      if (returned_v_r_i) valid[ret_idx] <= 1'b1;
      if (deq) begin
        valid[head] <= 1'b0;
        head        <= next_idx(head);
      end
      case ({alloc, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: slot data is qualified by its valid bit, so the storage array carries no reset.
  always_ff @(posedge clk_i) begin
    if (returned_v_r_i) data_mem[ret_idx] <= returned_data_r_i;
  end

`ifdef BRG_CGRA_MEM_ADAPTER_STATS_EN
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      stat_req_o   <= '0;
      stat_stall_o <= '0;
    end else begin
      if (alloc)                            stat_req_o   <= stat_req_o + 32'd1;
      if (cgra_req_v_i & ~cgra_req_ready_o) stat_stall_o <= stat_stall_o + 32'd1;
    end
  end
`endif

  // A return must target a slot between head and tail that has not already returned.
  logic [lg_els_lp-1:0] ret_offset;
  assign ret_offset = ret_idx - head;

  ret_to_live_slot: assert property (@(posedge clk_i) disable iff (reset_i)
    returned_v_r_i |-> (!valid[ret_idx] && (cnt_width_lp'(ret_offset) < count)));

endmodule
